issue_controller: RTL and testbench
===================================

# issue_controller

Instruction-issue controller for the five-stage pipelined datapath. It owns the IF/ID register and decodes each accepted instruction into the ID-stage control words (WBID, MEID, EXID). The datapath has no forwarding and no flush input, so the controller inserts bubbles on register read-after-write hazards and holds issue while a branch resolves in MEM. It sits between the instruction-fetch source and the datapath's `instr` and control inputs.

## Interface
- `STALL_CNT_W`, 16 — width of the saturating stall-cycle counter.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `instr_in`  in  32  — fetched instruction.
- `instr_valid`  in  1  — `instr_in` is valid.
- `instr_ready`  out  1  — controller accepts `instr_in` at this rising edge.
- `branch_taken`  in  1  — datapath `Branch`; sampled only in the resolve cycle.
- `instr`  out  32  — ID-stage instruction to the datapath; 0 on a bubble.
- `WBID`  out  2  — {RegWrite, ALUsel}; ALUsel=1 writes back the ALU result, 0 writes back memory data.
- `MEID`  out  3  — {Branch, MemRead, MemWrite}.
- `EXID`  out  4  — {RegDst, ALUOp1, ALUOp0, ALUSrc}; RegDst=1 selects Rt.
- `issue`  out  1  — a real instruction is on `instr`/controls this cycle.
- `resolve`  out  1  — 1-cycle pulse: a branch is in MEM this cycle.
- `redirect`  out  1  — `resolve & branch_taken`; fetch must redirect.
- `illegal`  out  1  — sticky; set when an unknown opcode has been consumed.
- `stall_cnt`  out  STALL_CNT_W  — saturating count of hazard-stall cycles.

## Operation
- Decode by `instr[31:26]`; control tuples are {WBID, MEID, EXID}:
  - R-type (000000): {11, 000, 0100}. Reads Rs and Rt. Writes Rd.
  - addi (001000): {11, 000, 1001}. Reads Rs. Writes Rt.
  - lw (100011): {10, 010, 1001}. Reads Rs. Writes Rt.
  - sw (101011): {00, 001, 1001}. Reads Rs and Rt.
  - beq (000100): {00, 100, 0010}. Reads Rs and Rt.
  - Any other opcode is consumed as a bubble and sets `illegal`.
- Scoreboard of 3 entries {valid, dest[4:0]}: sb0 = EX, sb1 = MEM, sb2 = WB.
  - Shifts every cycle.
  - sb0 loads the issued destination when RegWrite=1; otherwise it loads invalid.
  - Destination register 0 is never recorded.
- Hazard: the ID instruction is valid and a source it reads equals a valid entry in sb0, sb1 or sb2.
  - Result: bubble (`instr`=0, all controls 0, `issue`=0), the ID register holds, and `stall_cnt` increments, saturating at all-ones.
- `instr_ready` = state RUN & (ID empty | (issuing & not beq)).
- FSM states:
  - RUN: normal issue. Issuing a beq moves to BR_WAIT with count=0.
  - BR_WAIT: bubbles; `instr_ready`=0; the ID register is empty. Count 0 means beq is in EX. Count 1 means beq is in MEM: assert `resolve`, drive `redirect`, then return to RUN.
- `branch_taken` is ignored outside the resolve cycle.

## Timing
- Instruction accepted at edge N: on outputs during cycle N+1 if there is no hazard.
- Back-to-back independent instructions: one per cycle.
- Load-use and any RAW hazard: up to 3 bubble cycles, or 2 with bypass (see Configuration).
- beq issued in cycle N:
  - `resolve` in cycle N+2.
  - Next accept at edge N+3; next issue in N+4.
- Hazard on a beq in ID: it stalls before issue; branch sequencing starts at its issue cycle.
- Reset (any time, including mid-BR_WAIT or mid-stall):
  - State → RUN; ID register and scoreboard cleared.
  - Outputs `instr`, WBID, MEID, EXID, `issue`, `resolve`, `redirect`, `illegal`, `stall_cnt` = 0.
  - `instr_ready`=1 after reset deasserts.

## Configuration
- `ISSUE_WB_BYPASS_EN` defined: the register file is write-through, so sb2 is excluded from hazard checks. Maximum stall is 2 cycles.
- Not defined: sb2 participates in hazard checks. Maximum stall is 3 cycles.

## Structure
- Package `issue_pkg`:
  - Opcode localparams.
  - Control-tuple constants per instruction class.
  - Scoreboard entry typedef.
  - FSM state enum.
- Sub-module `issue_decode`: combinational opcode → {controls, reads_rs, reads_rt, dest, legal}.

## Test plan
- Reset, then stream `add $3,$1,$2` and `sub $6,$4,$5` → `issue` on consecutive cycles; controls 11/000/0100; `stall_cnt`=0.
- `lw $2,0($1)` then `add $4,$2,$3` → 3 bubbles (2 with `ISSUE_WB_BYPASS_EN`); `stall_cnt`=3 (2); add issues after the bubbles.
- `beq` with `branch_taken`=1 at N+2 → `resolve`=`redirect`=1 in N+2 only; `instr_ready`=0 in N..N+2.
- `beq` with `branch_taken`=0 at N+2, plus `branch_taken` pulsed at N+1 → `redirect` stays 0; `resolve`=1 in N+2.
- Opcode 111111, then `add` → bubble issued; `illegal`=1 and stays 1; add issues normally.
- Assert `rst`=0 during BR_WAIT count 1 → all outputs 0 immediately; after release, `instr_ready`=1 and state is RUN.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared definitions for the instruction-issue controller: opcodes, ID-stage
// control tuples, the hazard scoreboard entry and the branch-sequencing FSM.
package issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // {WBID, MEID, EXID} = {RegWrite, ALUsel}, {Branch, MemRead, MemWrite},
  // {RegDst, ALUOp1, ALUOp0, ALUSrc}
  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] me;
    logic [3:0] ex;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE  = '{wb: 2'b00, me: 3'b000, ex: 4'b0000};
  localparam ctrl_t CTRL_RTYPE = '{wb: 2'b11, me: 3'b000, ex: 4'b0100};
  localparam ctrl_t CTRL_ADDI  = '{wb: 2'b11, me: 3'b000, ex: 4'b1001};
  localparam ctrl_t CTRL_LW    = '{wb: 2'b10, me: 3'b010, ex: 4'b1001};
  localparam ctrl_t CTRL_SW    = '{wb: 2'b00, me: 3'b001, ex: 4'b1001};
  localparam ctrl_t CTRL_BEQ   = '{wb: 2'b00, me: 3'b100, ex: 4'b0010};

  // One pending register write: entry 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_entry_t;

  localparam int SB_DEPTH = 3;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/issue_decode.sv
// Combinational opcode decode: control tuple, which source registers the
// instruction reads, the destination it writes, and whether it is legal.
module issue_decode
  import issue_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  output ctrl_t      ctrl_o,
  output logic       reads_rs_o,
  output logic       reads_rt_o,
  output logic [4:0] dest_o,
  output logic       legal_o
);

  // Map the opcode onto its control tuple and register usage
  always_comb begin
    ctrl_o     = CTRL_NONE;
    reads_rs_o = 1'b0;
    reads_rt_o = 1'b0;
    dest_o     = 5'd0;
    legal_o    = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o     = CTRL_RTYPE;
        reads_rs_o = 1'b1;
        reads_rt_o = 1'b1;
        dest_o     = rd_i;
      end
      OP_ADDI: begin
        ctrl_o     = CTRL_ADDI;
        reads_rs_o = 1'b1;
        dest_o     = rt_i;
      end
      OP_LW: begin
        ctrl_o     = CTRL_LW;
        reads_rs_o = 1'b1;
        dest_o     = rt_i;
      end
      OP_SW: begin
        ctrl_o     = CTRL_SW;
        reads_rs_o = 1'b1;
        reads_rt_o = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o     = CTRL_BEQ;
        reads_rs_o = 1'b1;
        reads_rt_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/issue_controller.sv
// Instruction-issue controller: owns the IF/ID register, decodes into the
// ID-stage control words, inserts bubbles on RAW hazards and holds issue
// while a beq resolves in MEM.
// Optional feature macro ISSUE_WB_BYPASS_EN: when defined, the register file
// is write-through so the WB scoreboard entry is not checked for hazards.
module issue_controller
  import issue_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr_in,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic                   branch_taken,
  output logic [31:0]            instr,
  output logic [1:0]             WBID,
  output logic [2:0]             MEID,
  output logic [3:0]             EXID,
  output logic                   issue,
  output logic                   resolve,
  output logic                   redirect,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

`ifdef ISSUE_WB_BYPASS_EN
  localparam logic [SB_DEPTH-1:0] SB_CHECK_MASK = 3'b011;
`else
  localparam logic [SB_DEPTH-1:0] SB_CHECK_MASK = 3'b111;
`endif

  state_e                 state_q, state_d;
  logic                   br_cnt_q, br_cnt_d;
  logic                   id_valid_q, id_valid_d;
  logic [31:0]            id_instr_q, id_instr_d;
  sb_entry_t              sb_q [SB_DEPTH];
  sb_entry_t              sb_d [SB_DEPTH];
  logic                   illegal_q, illegal_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  ctrl_t                  dec_ctrl;
  ctrl_t                  out_ctrl;
  logic                   dec_reads_rs, dec_reads_rt, dec_legal;
  logic [4:0]             dec_dest;
  logic [4:0]             id_rs, id_rt;
  logic [SB_DEPTH-1:0]    sb_hit;
  logic                   hazard, consume, issuing, is_beq, accept, sb_load_valid;

  assign id_rs = id_instr_q[25:21];
  assign id_rt = id_instr_q[20:16];

  issue_decode u_decode (
    .opcode_i   (id_instr_q[31:26]),
    .rt_i       (id_rt),
    .rd_i       (id_instr_q[15:11]),
    .ctrl_o     (dec_ctrl),
    .reads_rs_o (dec_reads_rs),
    .reads_rt_o (dec_reads_rt),
    .dest_o     (dec_dest),
    .legal_o    (dec_legal)
  );

  // Per-entry source match against pending writes; the shift chain moves
  // the issued destination EX -> MEM -> WB every cycle, bubbles load invalid.
  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_sb
    assign sb_hit[gi] = SB_CHECK_MASK[gi] & sb_q[gi].valid &
                        ((dec_reads_rs & (sb_q[gi].dest == id_rs)) |
                         (dec_reads_rt & (sb_q[gi].dest == id_rt)));
    if (gi == 0) begin : g_head
      assign sb_d[gi] = '{valid: sb_load_valid, dest: dec_dest};
    end else begin : g_tail
      assign sb_d[gi] = sb_q[gi-1];
    end
  end

  // Register 0 is hard-wired, so writes to it never create a hazard.
  assign sb_load_valid = issuing & dec_ctrl.wb[1] & (dec_dest != 5'd0);

  assign hazard  = id_valid_q & (|sb_hit);
  assign consume = id_valid_q & ~hazard & (state_q == ST_RUN);
  assign issuing = consume & dec_legal;
  assign is_beq  = dec_ctrl.me[2];
  // Gated by rst so nothing is accepted while the controller is held in reset.
  assign instr_ready = rst & (state_q == ST_RUN) & (~id_valid_q | (consume & ~is_beq));
  assign accept      = instr_ready & instr_valid;

  assign out_ctrl  = issuing ? dec_ctrl : CTRL_NONE;
  assign instr     = issuing ? id_instr_q : 32'd0;
  assign WBID      = out_ctrl.wb;
  assign MEID      = out_ctrl.me;
  assign EXID      = out_ctrl.ex;
  assign issue     = issuing;
  assign resolve   = (state_q == ST_BR_WAIT) & br_cnt_q;
  assign redirect  = resolve & branch_taken;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_cnt_q;

  // Next-state for the ID register, branch FSM, sticky illegal and stall counter
  always_comb begin
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    state_d     = state_q;
    br_cnt_d    = br_cnt_q;
    illegal_d   = illegal_q | (consume & ~dec_legal);
    stall_cnt_d = stall_cnt_q;

    if (accept) begin
      id_valid_d = 1'b1;
      id_instr_d = instr_in;
    end else if (consume) begin
      id_valid_d = 1'b0;
    end

    if (hazard && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (issuing && is_beq) begin
          state_d  = ST_BR_WAIT;
          br_cnt_d = 1'b0;
        end
      end
      ST_BR_WAIT: begin
        // count 0: beq in EX; count 1: beq in MEM (resolve cycle)
        if (br_cnt_q) begin
          state_d  = ST_RUN;
          br_cnt_d = 1'b0;
        end else begin
          br_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_RUN;
        br_cnt_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      br_cnt_q    <= 1'b0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= 32'd0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      br_cnt_q    <= br_cnt_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= sb_d[i];
    end
  end

endmodule

// File: tb/tb_issue_controller.sv
// Randomised scoreboard bench for issue_controller. The reference model
// tracks, per architectural register, the first cycle a reader may issue,
// and derives issue cycles, stalls, ready and branch-resolve timing from that.
`timescale 1ns/1ps
module tb_issue_controller;

  localparam int W = 16;
`ifdef ISSUE_WB_BYPASS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_in = 32'd0;
  logic        instr_valid = 1'b0;
  logic        branch_taken = 1'b0;
  logic        instr_ready;
  logic [31:0] instr;
  logic [1:0]  WBID;
  logic [2:0]  MEID;
  logic [3:0]  EXID;
  logic        issue, resolve, redirect, illegal;
  logic [W-1:0] stall_cnt;

  issue_controller #(.STALL_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_taken(branch_taken), .instr(instr),
    .WBID(WBID), .MEID(MEID), .EXID(EXID), .issue(issue), .resolve(resolve),
    .redirect(redirect), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [31:0] ins;
    logic [8:0]  ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   in_reset = 1'b1;

  // Reference model state
  int rdy [32];
  bit pend_valid;
  int pend_start, pend_t;
  int stall_done;
  int illegal_from;
  int br_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic void decode_ref(input logic [31:0] ins, output bit legal, output bit rrs,
                                     output bit rrt, output int dst, output logic [8:0] ctrl);
    legal = 1'b1; rrs = 1'b1; rrt = 1'b0; dst = 0; ctrl = 9'd0;
    case (ins[31:26])
      6'b000000: begin rrt = 1'b1; dst = int'(ins[15:11]); ctrl = 9'b11_000_0100; end
      6'b001000: begin dst = int'(ins[20:16]); ctrl = 9'b11_000_1001; end
      6'b100011: begin dst = int'(ins[20:16]); ctrl = 9'b10_010_1001; end
      6'b101011: begin rrt = 1'b1; ctrl = 9'b00_001_1001; end
      6'b000100: begin rrt = 1'b1; ctrl = 9'b00_100_0010; end
      default:   begin legal = 1'b0; rrs = 1'b0; end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rdy[i] = 0;
    pend_valid   = 1'b0;
    pend_start   = 0;
    pend_t       = 0;
    stall_done   = 0;
    illegal_from = 1 << 30;
    br_t         = -100;
    exp_q.delete();
  endtask

  task automatic model_accept(input int a, input logic [31:0] ins);
    bit legal, rrs, rrt;
    int dst, t, rs, rt;
    logic [8:0] ctrl;
    decode_ref(ins, legal, rrs, rrt, dst, ctrl);
    if (pend_valid) stall_done += pend_t - pend_start;
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    t  = a + 1;
    if (rrs && rdy[rs] > t) t = rdy[rs];
    if (rrt && rdy[rt] > t) t = rdy[rt];
    pend_valid = 1'b1;
    pend_start = a + 1;
    pend_t     = t;
    if (legal) exp_q.push_back('{t, ins, ctrl});
    else if (t + 1 < illegal_from) illegal_from = t + 1;
    if (legal && ctrl[8] && dst != 0) rdy[dst] = t + LAT;
    if (ins[31:26] == 6'b000100) br_t = t;
    $display("accept cycle %0d instr=%08h expect issue cycle %0d%s", a, ins, t,
             legal ? "" : " (illegal opcode, bubble)");
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    int sel;
    rs  = 5'($urandom_range(0, 5));
    rt  = 5'($urandom_range(0, 5));
    rd  = 5'($urandom_range(0, 5));
    sel = $urandom_range(0, 11);
    if (sel <= 3)       return rtype(rs, rt, rd, 6'($urandom_range(32, 42)));
    else if (sel <= 5)  return itype(6'b001000, rs, rt, 16'($urandom));
    else if (sel <= 7)  return itype(6'b100011, rs, rt, 16'($urandom));
    else if (sel <= 9)  return itype(6'b101011, rs, rt, 16'($urandom));
    else if (sel == 10) return itype(6'b000100, rs, rt, 16'h0004);
    else                return itype(($urandom_range(0, 1) == 1) ? 6'b111111 : 6'b000010, rs, rt, 16'h0);
  endfunction

  // Called at posedge+1; leaves the bench at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] ins);
    int waited = 0;
    bit done = 1'b0;
    instr_in    = ins;
    instr_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      #2;
      if (instr_ready) begin
        model_accept(cyc, ins);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 40) begin
          check("accept_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic gap(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, 64'(instr), 64'd0);
    check({tag, "_WBID"}, 64'(WBID), 64'd0);
    check({tag, "_MEID"}, 64'(MEID), 64'd0);
    check({tag, "_EXID"}, 64'(EXID), 64'd0);
    check({tag, "_issue"}, 64'(issue), 64'd0);
    check({tag, "_resolve"}, 64'(resolve), 64'd0);
    check({tag, "_redirect"}, 64'(redirect), 64'd0);
    check({tag, "_illegal"}, 64'(illegal), 64'd0);
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
  endtask

  // branch_taken toggles randomly; only the resolve cycle may act on it
  initial begin
    forever begin
      @(posedge clk);
      #1 branch_taken = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops expected issues and checks per-cycle outputs
  initial begin
    int   c, es, lo;
    bit   exp_issue, exp_ready, exp_res;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        c = cyc;
        exp_issue = (exp_q.size() > 0) && (exp_q[0].t == c);
        check("issue", 64'(issue), 64'(exp_issue));
        if (exp_issue) begin
          e = exp_q.pop_front();
          if (issue) begin
            check("instr", 64'(instr), 64'(e.ins));
            check("ctrl", 64'({WBID, MEID, EXID}), 64'(e.ctrl));
          end
        end else begin
          check("bubble_instr", 64'(instr), 64'd0);
          check("bubble_ctrl", 64'({WBID, MEID, EXID}), 64'd0);
        end
        exp_ready = 1'b1;
        if (c >= br_t && c <= br_t + 2) exp_ready = 1'b0;
        if (pend_valid && c >= pend_start && c < pend_t) exp_ready = 1'b0;
        check("instr_ready", 64'(instr_ready), 64'(exp_ready));
        exp_res = (c == br_t + 2);
        check("resolve", 64'(resolve), 64'(exp_res));
        check("redirect", 64'(redirect), 64'(exp_res & branch_taken));
        check("illegal", 64'(illegal), 64'(c >= illegal_from));
        es = stall_done;
        if (pend_valid) begin
          lo = (c < pend_t) ? c : pend_t;
          if (lo > pend_start) es += lo - pend_start;
        end
        check("stall_cnt", 64'(stall_cnt), 64'(es));
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] prog[$];
    int n;
    model_reset();
    rst = 1'b0;
    in_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b1;
    #1 check("ready_after_reset", 64'(instr_ready), 64'd1);
    in_reset = 1'b0;
    @(posedge clk);
    #1;

    prog.push_back(rtype(5'd1, 5'd2, 5'd3, 6'h20));          // add $3,$1,$2
    prog.push_back(rtype(5'd4, 5'd5, 5'd6, 6'h22));          // sub $6,$4,$5
    prog.push_back(itype(6'b100011, 5'd1, 5'd2, 16'd0));     // lw  $2,0($1)
    prog.push_back(rtype(5'd2, 5'd3, 5'd4, 6'h20));          // add $4,$2,$3
    prog.push_back(itype(6'b000100, 5'd1, 5'd7, 16'd4));    // beq $1,$7
    prog.push_back(itype(6'b111111, 5'd0, 5'd0, 16'd0));     // illegal
    prog.push_back(rtype(5'd1, 5'd2, 5'd3, 6'h20));          // add
    for (int i = 0; i < 300; i++) prog.push_back(rand_instr());

    foreach (prog[i]) begin
      send(prog[i]);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end

    // Reset while the beq sits in MEM (BR_WAIT count 1)
    gap(8);
    send(itype(6'b000100, 5'd1, 5'd2, 16'd4));
    n = 0;
    while (cyc != br_t + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_resolve_cycle", 64'(cyc), 64'(br_t + 2));
    #2;
    in_reset = 1'b1;
    rst = 1'b0;
    #1 check_reset_outputs("mid_branch_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1 check("ready_after_mid_reset", 64'(instr_ready), 64'd1);
    in_reset = 1'b0;
    @(posedge clk);
    #1;
    send(rtype(5'd1, 5'd2, 5'd3, 6'h20));
    send(rtype(5'd4, 5'd5, 5'd6, 6'h22));

    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
